// File: rtl/mem_rsp_pkg.sv
// Shared types, default widths and parameter legality checks for the
// flow-controlled parametrised memory.
package mem_rsp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

    // Default-width response entry; modules with other widths declare a local copy.
    typedef struct packed {
        logic                  err;
        logic [DEF_DATA_W-1:0] data;
    } rsp_t;

    function automatic bit data_w_ok(input int data_w);
        return (data_w >= 32'sd8) && ((data_w % 32'sd8) == 32'sd0);
    endfunction

    function automatic bit depth_ok(input int addr_w, input int depth);
        return (depth >= 32'sd1) && (depth <= (32'sd1 << addr_w));
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat, input int rsp_depth);
        return (rd_lat >= 32'sd1) && (rd_lat <= 32'sd4) && (rsp_depth >= rd_lat + 32'sd1);
    endfunction

    function automatic bit params_ok(input int data_w, input int addr_w, input int depth,
                                     input int rd_lat, input int rsp_depth);
        return data_w_ok(data_w) && depth_ok(addr_w, depth) && rd_lat_ok(rd_lat, rsp_depth);
    endfunction

endpackage

// File: rtl/mem_rsp_chk.sv
// Protocol checker for the response buffer and credit counter.
module mem_rsp_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             i_push,
    input logic             i_pop,
    input logic             i_full,
    input logic             i_empty,
    input logic [CNT_W-1:0] i_count,
    input logic [CNT_W-1:0] i_inflight
);

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(i_push && i_full && !i_pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && i_empty));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst) (i_count <= i_inflight));

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding read responses; supports push and pop in the
// same cycle, including when full.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH-1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Entry storage; contents are don't-care until pushed, so not reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/param_mem_rsp.sv
// Parametrised single-port memory with valid/ready requests and a buffered,
// credit-controlled read response channel.
module param_mem_rsp
    import mem_rsp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(RSP_DEPTH+1);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_loc_t;

    if (!params_ok(DATA_W, ADDR_W, DEPTH, RD_LAT, RSP_DEPTH)) begin : g_bad_params
        $error("param_mem_rsp: illegal parameter combination");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  w_inflight_nxt;
    logic              r_ready_ok;
    logic              w_addr_ok;
    logic              w_wr_hs;
    logic              w_rd_hs;
    logic              w_pop;
    logic              w_push;
    rsp_loc_t          w_rd_entry;
    rsp_loc_t          w_push_entry;
    rsp_loc_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;

    assign w_addr_ok  = (32'(req_addr) < 32'(DEPTH));
    assign w_wr_hs    = req_valid && req_ready && req_write;
    assign w_rd_hs    = req_valid && req_ready && !req_write;
    assign w_rd_entry = w_addr_ok ? '{err: 1'b0, data: r_mem[req_addr]}
                                  : '{err: 1'b1, data: {DATA_W{1'b0}}};

    // Byte-enabled write; out-of-range writes are dropped and the array is never reset.
    always_ff @(posedge clk) begin
        if (w_wr_hs && w_addr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at acceptance and delayed so it enters the buffer RD_LAT cycles later.
    if (RD_LAT == 1) begin : g_lat1
        assign w_push       = w_rd_hs;
        assign w_push_entry = w_rd_entry;
    end else begin : g_pipe
        logic     r_pv [RD_LAT-1];
        rsp_loc_t r_pd [RD_LAT-1];

        // Shift register of in-flight reads; valids cleared on reset so nothing stale survives.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < RD_LAT-1; i++) begin
                    r_pv[i] <= 1'b0;
                end
            end else begin
                r_pv[0] <= w_rd_hs;
                for (int i = 1; i < RD_LAT-1; i++) begin
                    r_pv[i] <= r_pv[i-1];
                end
            end
            r_pd[0] <= w_rd_entry;
            for (int i = 1; i < RD_LAT-1; i++) begin
                r_pd[i] <= r_pd[i-1];
            end
        end

        assign w_push       = r_pv[RD_LAT-2];
        assign w_push_entry = r_pd[RD_LAT-2];
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_pop = rsp_valid && rsp_ready;

    // Credit update: one per accepted read, released on each response handshake.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_rd_hs && !w_pop) begin
            w_inflight_nxt = r_inflight + CNT_W'(1);
        end else if (!w_rd_hs && w_pop) begin
            w_inflight_nxt = r_inflight - CNT_W'(1);
        end else begin
            w_inflight_nxt = r_inflight;
        end
    end

    // Credit register and registered acceptance; held low on the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= {CNT_W{1'b0}};
            r_ready_ok <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_ready_ok <= (w_inflight_nxt < CNT_W'(RSP_DEPTH));
        end
    end

    assign req_ready = !rst && r_ready_ok;
    assign rsp_valid = !rst && !w_empty;
    assign rsp_rdata = rsp_valid ? w_head.data : {DATA_W{1'b0}};
    assign rsp_err   = rsp_valid && w_head.err;
    assign busy      = !rst && (r_inflight != {CNT_W{1'b0}});

    mem_rsp_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_full     (w_full),
        .i_empty    (w_empty),
        .i_count    (w_count),
        .i_inflight (r_inflight)
    );

endmodule

// File: tb/tb_param_mem_rsp.sv
// Randomised self-checking bench for param_mem_rsp against a transaction-level model.
module tb_param_mem_rsp;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 12;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [3:0]        req_be = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    param_mem_rsp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: memory image plus a FIFO of expected responses, each with the cycle it becomes visible.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic [31:0] ref_mem [DEPTH];
    exp_t        q[$];
    int          cyc = 0;
    bit          post_rst = 1'b0;
    logic        tb_rr = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic tick(input logic v, input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic rr, input logic r, output logic acc);
        logic e_rdy;
        logic e_vld;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        rsp_ready = rr; rst = r;
        #1;
        e_rdy = !r && !post_rst && (q.size() < RSP_DEPTH);
        e_vld = 1'b0;
        if (!r && q.size() > 0) e_vld = (q[0].due <= cyc);
        check_val("req_ready", {31'b0, req_ready}, {31'b0, e_rdy});
        check_val("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_vld});
        check_val("busy", {31'b0, busy}, {31'b0, (!r && q.size() != 0)});
        if (e_vld) begin
            check_val("rsp_rdata", rsp_rdata, q[0].data);
            check_val("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
        end else if (r || post_rst) begin
            check_val("rst_rdata", rsp_rdata, 32'h0);
            check_val("rst_err", {31'b0, rsp_err}, 32'h0);
        end
        acc = v && e_rdy;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            post_rst = 1'b1;
        end else begin
            post_rst = 1'b0;
            if (e_vld && rr) void'(q.pop_front());
            if (acc) begin
                if (w) begin
                    if (int'(a) < DEPTH)
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end else begin
                    if (int'(a) < DEPTH) q.push_back('{data: ref_mem[a], err: 1'b0, due: cyc + RD_LAT - 1});
                    else                 q.push_back('{data: 32'h0, err: 1'b1, due: cyc + RD_LAT - 1});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, tb_rr, 1'b0, acc);
    endtask

    // Hold a request until accepted, with a bounded wait.
    task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) tick(1'b1, w, a, d, be, tb_rr, 1'b0, acc);
        check_val("issue_accepted", {31'b0, acc}, 32'h1);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   t0;
        // Reset for two cycles, then the first cycle after must still refuse requests.
        tick(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
        tick(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
        tick(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, acc);
        check_val("post_rst_ready", {31'b0, req_ready}, 32'h1);

        // Give every word a known random value.
        tb_rr = 1'b1;
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 4'(i), $urandom, 4'hF);

        // Full write then read, and partial byte-enable merge.
        issue(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 4'd3, 32'h0, 4'h0);
        issue(1'b1, 4'd5, 32'h11223344, 4'hF);
        issue(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 4'd5, 32'h0, 4'h0);
        idle(4);
        check_val("be_merge_model", ref_mem[5], 32'h11BB33DD);

        // Out-of-range read and dropped out-of-range write, then re-read the whole array.
        issue(1'b0, 4'd13, 32'h0, 4'h0);
        issue(1'b1, 4'd14, 32'hFFFFFFFF, 4'hF);
        issue(1'b0, 4'd14, 32'h0, 4'h0);
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 4'(i), 32'h0, 4'h0);
        idle(6);

        // Backpressure: four credits only, then drain in order.
        tb_rr = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 4'(i), 32'h0, 4'h0);
        idle(2);
        check_val("full_ready_low", {31'b0, req_ready}, 32'h0);
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 1'b0, 1'b0, acc);
            if (acc) n_acc++;
        end
        check_val("no_acc_when_full", 32'(n_acc), 32'h0);
        tb_rr = 1'b1;
        issue(1'b0, 4'd4, 32'h0, 4'h0);
        issue(1'b0, 4'd5, 32'h0, 4'h0);
        idle(8);

        // Back-to-back throughput.
        t0 = cyc;
        for (int i = 0; i < 8; i++) issue(1'b0, 4'(i), 32'h0, 4'h0);
        check_val("b2b_accept_cycles", 32'(cyc - t0), 32'd8);
        idle(6);

        // Reset with reads outstanding; memory survives.
        tb_rr = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, 4'(i), 32'h0, 4'h0);
        tick(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
        idle(6);
        tb_rr = 1'b1;
        issue(1'b0, 4'd3, 32'h0, 4'h0);
        idle(4);
        check_val("mem_kept_model", ref_mem[3], 32'hDEADBEEF);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 149) == 0, acc);
        end
        tb_rr = 1'b1;
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
